// File: rtl/tx_stream_ctrl_if.sv
// RX byte stream and FIFO write-side signals between the stream controller and its surroundings.
// The controller uses the slave view. The host side (RX source plus FIFO) uses the master view.
interface tx_stream_ctrl_if;
    logic [7:0] rx_data_si;
    logic       rx_valid_si;
    logic       rx_ready_si;
    logic [7:0] fifo_wr_data;
    logic       fifo_wr_en;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic       fifo_flush;

    modport slave (
        input  rx_data_si,
        input  rx_valid_si,
        output rx_ready_si,
        output fifo_wr_data,
        output fifo_wr_en,
        output fifo_flush,
        input  fifo_full,
        input  fifo_empty,
        input  fifo_rd_en
    );

    modport master (
        output rx_data_si,
        output rx_valid_si,
        input  rx_ready_si,
        input  fifo_wr_data,
        input  fifo_wr_en,
        input  fifo_flush,
        output fifo_full,
        output fifo_empty,
        output fifo_rd_en
    );
endinterface

// File: rtl/tx_stream_ctrl.sv
// Run controller: splits escape commands from sample bytes, writes samples into the FIFO,
// tracks FIFO occupancy and sequences the modulator through STOP/PREFILL/RUN/DRAIN.
module tx_stream_ctrl #(
    parameter int         DEPTH_WIDTH = 8,
    parameter int         START_LEVEL = 128,
    parameter logic [7:0] ESC_BYTE    = 8'h1B
) (
    input  logic                 clk,
    input  logic                 rst,
    tx_stream_ctrl_if.slave      bus,
    output logic                 mod_enable,
    output logic [DEPTH_WIDTH:0] level,
    output logic [1:0]           run_state,
    output logic [7:0]           underrun_cnt,
    output logic                 cmd_err
);

    localparam logic [DEPTH_WIDTH:0] FULL_LVL  = {1'b1, {DEPTH_WIDTH{1'b0}}};
    localparam logic [DEPTH_WIDTH:0] START_LVL = (DEPTH_WIDTH+1)'(START_LEVEL);
    localparam logic [7:0] CMD_START = 8'h01;
    localparam logic [7:0] CMD_STOP  = 8'h02;
    localparam logic [7:0] CMD_FLUSH = 8'h03;

    typedef enum logic [1:0] {
        ST_STOP    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_RUN     = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    typedef enum logic {
        P_NORMAL = 1'b0,
        P_ESC    = 1'b1
    } parse_t;

    state_t               state_reg, state_next;
    parse_t               parse_reg, parse_next;
    logic                 alive_reg;
    logic                 wr_en_reg, wr_en_next;
    logic [7:0]           wr_data_reg, wr_data_next;
    logic                 flush_reg;
    logic                 mod_en_reg;
    logic [DEPTH_WIDTH:0] level_reg, level_next;
    logic [7:0]           underrun_reg, underrun_next;
    logic                 cmd_err_reg;

    logic accept;
    logic rd_ok;
    logic cmd_start, cmd_stop, cmd_flush, cmd_bad;

    // alive_reg keeps the RX port closed until the first clock after reset release
    assign bus.rx_ready_si  = alive_reg & ~bus.fifo_full & ~flush_reg;
    assign accept           = bus.rx_valid_si & bus.rx_ready_si;
    assign rd_ok            = bus.fifo_rd_en & ~bus.fifo_empty;

    assign bus.fifo_wr_en   = wr_en_reg;
    assign bus.fifo_wr_data = wr_data_reg;
    assign bus.fifo_flush   = flush_reg;
    assign mod_enable       = mod_en_reg;
    assign level            = level_reg;
    assign run_state        = state_reg;
    assign underrun_cnt     = underrun_reg;
    assign cmd_err          = cmd_err_reg;

    always_comb begin
        parse_next   = parse_reg;
        wr_en_next   = 1'b0;
        wr_data_next = wr_data_reg;
        cmd_start    = 1'b0;
        cmd_stop     = 1'b0;
        cmd_flush    = 1'b0;
        cmd_bad      = 1'b0;
        if (accept) begin
            if (parse_reg == P_NORMAL) begin
                if (bus.rx_data_si == ESC_BYTE) begin
                    parse_next = P_ESC;
                end else begin
                    wr_en_next   = 1'b1;
                    wr_data_next = bus.rx_data_si;
                end
            end else begin
                parse_next = P_NORMAL;
                if (bus.rx_data_si == ESC_BYTE) begin
                    wr_en_next   = 1'b1;
                    wr_data_next = ESC_BYTE;
                end else if (bus.rx_data_si == CMD_START) begin
                    cmd_start = 1'b1;
                end else if (bus.rx_data_si == CMD_STOP) begin
                    cmd_stop = 1'b1;
                end else if (bus.rx_data_si == CMD_FLUSH) begin
                    cmd_flush = 1'b1;
                end else begin
                    cmd_bad = 1'b1;
                end
            end
        end
    end

    // Level tracking saturates at both ends; flush (command or pulse cycle) forces zero
    always_comb begin
        level_next = level_reg;
        if (wr_en_reg && !rd_ok) begin
            if (level_reg != FULL_LVL) level_next = level_reg + 1'b1;
        end else if (rd_ok && !wr_en_reg) begin
            if (level_reg != '0) level_next = level_reg - 1'b1;
        end
        if (cmd_flush || flush_reg) level_next = '0;
    end

    // An effective command takes priority over the level/empty transition in the same cycle
    always_comb begin
        state_next    = state_reg;
        underrun_next = underrun_reg;
        case (state_reg)
            ST_STOP: begin
                if (cmd_start) state_next = ST_PREFILL;
            end
            ST_PREFILL: begin
                if (cmd_stop)                    state_next = ST_STOP;
                else if (level_reg >= START_LVL) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (cmd_stop) begin
                    state_next = ST_DRAIN;
                end else if (bus.fifo_empty) begin
                    state_next = ST_PREFILL;
                    if (underrun_reg != 8'hFF) underrun_next = underrun_reg + 8'd1;
                end
            end
            ST_DRAIN: begin
                if (cmd_start)           state_next = ST_RUN;
                else if (bus.fifo_empty) state_next = ST_STOP;
            end
            default: state_next = ST_STOP;
        endcase
        if (cmd_flush) state_next = ST_STOP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alive_reg    <= 1'b0;
            state_reg    <= ST_STOP;
            parse_reg    <= P_NORMAL;
            wr_en_reg    <= 1'b0;
            wr_data_reg  <= 8'h00;
            flush_reg    <= 1'b0;
            mod_en_reg   <= 1'b0;
            level_reg    <= '0;
            underrun_reg <= 8'h00;
            cmd_err_reg  <= 1'b0;
        end else begin
            alive_reg    <= 1'b1;
            state_reg    <= state_next;
            parse_reg    <= parse_next;
            wr_en_reg    <= wr_en_next;
            wr_data_reg  <= wr_data_next;
            flush_reg    <= cmd_flush;
            mod_en_reg   <= (state_next == ST_RUN) || (state_next == ST_DRAIN);
            level_reg    <= level_next;
            underrun_reg <= underrun_next;
            cmd_err_reg  <= cmd_bad;
        end
    end

endmodule
